// File: rtl/inst_rom_arbiter_pkg.sv
// Shared constants and helpers for the instruction ROM arbiter: ROM enable
// levels, bus widths, owner tags and the two-way winner selection function.
package inst_rom_arbiter_pkg;

    localparam logic        CHIP_ENABLE        = 1'b1;
    localparam logic        CHIP_DISABLE       = 1'b0;
    localparam logic [63:0] ZERO_DOUBLE_WORD   = 64'h0;
    localparam int          INST_ADDR_BUS      = 64;
    localparam int          INST_BUS           = 64;
    localparam int          INST_MEM_NUM_LOG2  = 17;

    // Owner tags double as the requester index into req/gnt vectors.
    localparam logic        REQ_IF             = 1'b0;
    localparam logic        REQ_DBG            = 1'b1;

    // Winner index for a non-empty request vector; ptr is the favoured side.
    function automatic logic rr_winner(input logic [1:0] req,
                                       input logic       ptr,
                                       input logic       if_prio);
        logic win;
        case (req)
            2'b01:   win = REQ_IF;
            2'b10:   win = REQ_DBG;
            2'b11:   win = if_prio ? REQ_IF : ptr;
            default: win = REQ_IF;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/inst_rom_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on contested cycles, or fixed IF priority
// when prio_mode is set. The pointer only moves when both sides request.
module rr_arb2
    import inst_rom_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;
    logic win_s;

    // Grant selection and next pointer (the loser of a contested cycle).
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        win_s = REQ_IF;
        if (req != 2'b00) begin
            win_s      = rr_winner(req, ptr_q, prio_mode);
            gnt[win_s] = 1'b1;
            if ((req == 2'b11) && !prio_mode) begin
                ptr_d = ~win_s;
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            gnt = 2'b00;
        end
    end

    // Pointer register; IF is favoured out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_IF;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the combinational instruction ROM between the fetch stage and the
// debug port: arbitrate, drive the ROM from a latched request, return data 2 cycles later.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W         = INST_ADDR_BUS,
    parameter int DATA_W         = INST_BUS,
    parameter int MEM_DEPTH_LOG2 = INST_MEM_NUM_LOG2,
    parameter bit IF_PRIORITY    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    input  logic              if_flush,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rerr,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rerr,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam int HI_LSB = MEM_DEPTH_LOG2 + 3;

    logic [1:0]        gnt_s;
    logic              b_err_s;
    logic              b_live_s;
    logic [DATA_W-1:0] b_word_s;

    logic              b_valid_q,   b_valid_d;
    logic              b_owner_q,   b_owner_d;
    logic [ADDR_W-1:0] b_addr_q,    b_addr_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              if_rerr_q,   if_rerr_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;
    logic              dbg_rerr_q,   dbg_rerr_d;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({dbg_req, if_req}),
        .prio_mode (IF_PRIORITY),
        .gnt       (gnt_s)
    );

    assign if_gnt     = gnt_s[REQ_IF];
    assign dbg_gnt    = gnt_s[REQ_DBG];
    assign if_stall   = if_req & ~gnt_s[REQ_IF];
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign if_rerr    = if_rerr_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_rerr   = dbg_rerr_q;

    // Stage B address check; an erroring request never enables the ROM.
    always_comb begin
        b_err_s  = (b_addr_q[2:0] != 3'b000) || (b_addr_q[ADDR_W-1:HI_LSB] != '0);
        rom_addr = b_addr_q;
        if (b_valid_q && !b_err_s) begin
            rom_ce = CHIP_ENABLE;
        end else begin
            rom_ce = CHIP_DISABLE;
        end
    end

    // Stage A: latch the granted request; a flushed IF grant is consumed but dropped.
    always_comb begin
        b_valid_d = 1'b0;
        b_owner_d = b_owner_q;
        b_addr_d  = b_addr_q;
        if (gnt_s[REQ_DBG]) begin
            b_valid_d = 1'b1;
            b_owner_d = REQ_DBG;
            b_addr_d  = dbg_addr;
        end else if (gnt_s[REQ_IF] && !if_flush) begin
            b_valid_d = 1'b1;
            b_owner_d = REQ_IF;
            b_addr_d  = if_addr;
        end else begin
            b_valid_d = 1'b0;
        end
    end

    // Stage B to C: capture ROM data for the owner; rdata holds otherwise.
    always_comb begin
        b_live_s     = b_valid_q && !(if_flush && (b_owner_q == REQ_IF));
        b_word_s     = b_err_s ? {DATA_W{1'b0}} : rom_inst;
        if_rvalid_d  = b_live_s && (b_owner_q == REQ_IF);
        dbg_rvalid_d = b_live_s && (b_owner_q == REQ_DBG);
        if_rerr_d    = if_rvalid_d && b_err_s;
        dbg_rerr_d   = dbg_rvalid_d && b_err_s;
        if (if_rvalid_d) begin
            if_rdata_d = b_word_s;
        end else begin
            if_rdata_d = if_rdata_q;
        end
        if (dbg_rvalid_d) begin
            dbg_rdata_d = b_word_s;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    // Pipeline and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid_q    <= 1'b0;
            b_owner_q    <= REQ_IF;
            b_addr_q     <= {ADDR_W{1'b0}};
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= {DATA_W{1'b0}};
            if_rerr_q    <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= {DATA_W{1'b0}};
            dbg_rerr_q   <= 1'b0;
        end else begin
            b_valid_q    <= b_valid_d;
            b_owner_q    <= b_owner_d;
            b_addr_q     <= b_addr_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_rerr_q    <= if_rerr_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rerr_q   <= dbg_rerr_d;
        end
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Scoreboard bench for inst_rom_arbiter: one round-robin and one IF-priority
// instance share stimulus; expected responses are queued at grant time.
module tb_inst_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, dbg_req = 1'b0, if_flush = 1'b0;
    logic [63:0] if_addr = 64'h0, dbg_addr = 64'h0;

    logic [1:0]  if_gnt_w, dbg_gnt_w, if_stall_w, if_rvalid_w, if_rerr_w;
    logic [1:0]  dbg_rvalid_w, dbg_rerr_w, rom_ce_w;
    logic [63:0] if_rdata_w [2];
    logic [63:0] dbg_rdata_w [2];
    logic [63:0] rom_addr_w [2];
    logic [63:0] rom_inst_w [2];

    typedef struct {
        int          d;
        int          o;
        int          due;
        logic [63:0] data;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ptr [2];
    logic        exp_ce [2];
    logic [63:0] exp_addr [2];
    logic [63:0] last_rd [2][2];

    always #5 clk = ~clk;

    function automatic logic [63:0] rom_word(input logic [63:0] a);
        logic [63:0] idx;
        idx = a >> 3;
        return {idx[31:0] ^ 32'h5A5A_0000, ~idx[31:0]};
    endfunction

    function automatic logic addr_bad(input logic [63:0] a);
        return (a[2:0] != 3'b000) || ((a >> 20) != 64'h0);
    endfunction

    assign rom_inst_w[0] = rom_ce_w[0] ? rom_word(rom_addr_w[0]) : 64'hDEAD_BEEF_DEAD_BEEF;
    assign rom_inst_w[1] = rom_ce_w[1] ? rom_word(rom_addr_w[1]) : 64'hDEAD_BEEF_DEAD_BEEF;

    inst_rom_arbiter #(.IF_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[0]), .if_stall(if_stall_w[0]),
        .if_flush(if_flush), .if_rvalid(if_rvalid_w[0]), .if_rdata(if_rdata_w[0]), .if_rerr(if_rerr_w[0]),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt_w[0]),
        .dbg_rvalid(dbg_rvalid_w[0]), .dbg_rdata(dbg_rdata_w[0]), .dbg_rerr(dbg_rerr_w[0]),
        .rom_ce(rom_ce_w[0]), .rom_addr(rom_addr_w[0]), .rom_inst(rom_inst_w[0])
    );

    inst_rom_arbiter #(.IF_PRIORITY(1'b1)) dut_pr (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[1]), .if_stall(if_stall_w[1]),
        .if_flush(if_flush), .if_rvalid(if_rvalid_w[1]), .if_rdata(if_rdata_w[1]), .if_rerr(if_rerr_w[1]),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt_w[1]),
        .dbg_rvalid(dbg_rvalid_w[1]), .dbg_rdata(dbg_rdata_w[1]), .dbg_rerr(dbg_rerr_w[1]),
        .rom_ce(rom_ce_w[1]), .rom_addr(rom_addr_w[1]), .rom_inst(rom_inst_w[1])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive, check grants, update model, then check responses.
    task automatic step(input logic ir, input logic [63:0] ia, input logic dr,
                        input logic [63:0] da, input logic fl, input logic rs);
        @(negedge clk);
        if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da; if_flush = fl; rst = rs;
        #1;
        for (int d = 0; d < 2; d++) begin
            int          win;
            logic        eg_if, eg_dbg, bad, load;
            logic [63:0] a;
            win = 0;
            if (ir && dr) win = (d == 1) ? 0 : ptr[d];
            else if (dr)  win = 1;
            eg_if  = ir && (win == 0);
            eg_dbg = dr && (win == 1);
            check_val($sformatf("d%0d_if_gnt", d), {63'h0, if_gnt_w[d]}, {63'h0, eg_if});
            check_val($sformatf("d%0d_dbg_gnt", d), {63'h0, dbg_gnt_w[d]}, {63'h0, eg_dbg});
            check_val($sformatf("d%0d_if_stall", d), {63'h0, if_stall_w[d]}, {63'h0, ir && !eg_if});
            a    = (win == 1) ? da : ia;
            bad  = addr_bad(a);
            load = (ir || dr) && !(fl && (win == 0));
            if (fl) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].d == d && sb[i].o == 0 && sb[i].due > cyc) sb.delete(i);
            end
            if (ir && dr && d == 0) ptr[d] = 1 - win;
            if (rs) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].d == d) sb.delete(i);
                ptr[d] = 0;
                exp_ce[d] = 1'b0;
                exp_addr[d] = 64'h0;
                last_rd[d][0] = 64'h0;
                last_rd[d][1] = 64'h0;
            end else if (load) begin
                sb.push_back('{d: d, o: win, due: cyc + 2,
                               data: bad ? 64'h0 : rom_word(a), err: bad});
                exp_ce[d] = !bad;
                exp_addr[d] = a;
            end else begin
                exp_ce[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("d%0d_rom_ce", d), {63'h0, rom_ce_w[d]}, {63'h0, exp_ce[d]});
            check_val($sformatf("d%0d_rom_addr", d), rom_addr_w[d], exp_addr[d]);
            for (int o = 0; o < 2; o++) begin
                int          idx;
                logic        ev, ee;
                logic        gv, ge;
                logic [63:0] gd;
                idx = -1;
                foreach (sb[i])
                    if (sb[i].d == d && sb[i].o == o && sb[i].due == cyc) idx = i;
                ev = (idx >= 0);
                ee = ev ? sb[idx].err : 1'b0;
                if (ev) begin
                    last_rd[d][o] = sb[idx].data;
                    sb.delete(idx);
                end
                gv = (o == 0) ? if_rvalid_w[d] : dbg_rvalid_w[d];
                ge = (o == 0) ? if_rerr_w[d] : dbg_rerr_w[d];
                gd = (o == 0) ? if_rdata_w[d] : dbg_rdata_w[d];
                check_val($sformatf("d%0d_o%0d_rvalid", d, o), {63'h0, gv}, {63'h0, ev});
                check_val($sformatf("d%0d_o%0d_rerr", d, o), {63'h0, ge}, {63'h0, ee});
                check_val($sformatf("d%0d_o%0d_rdata", d, o), gd, last_rd[d][o]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0; exp_ce[d] = 1'b0; exp_addr[d] = 64'h0;
            last_rd[d][0] = 64'h0; last_rd[d][1] = 64'h0;
        end
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1);
        idle(1);

        // IF-only streaming: words 4, 5, 6
        step(1'b1, 64'h20, 1'b0, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h28, 1'b0, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h30, 1'b0, 64'h0, 1'b0, 1'b0);
        idle(3);

        // both requesting every cycle
        for (int i = 0; i < 6; i++)
            step(1'b1, 64'h40 + 64'(8 * i), 1'b1, 64'h1000 + 64'(8 * i), 1'b0, 1'b0);
        idle(3);

        // address errors and the last legal word
        step(1'b1, 64'h104, 1'b0, 64'h0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 64'h10_0000, 1'b0, 64'h0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 64'h3, 1'b0, 1'b0);
        step(1'b1, 64'h0F_FFF8, 1'b0, 64'h0, 1'b0, 1'b0);
        idle(3);

        // flush: IF grants 0..2, flush in 2, DBG in 3
        step(1'b1, 64'h200, 1'b0, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h208, 1'b0, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h210, 1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 64'h300, 1'b0, 1'b0);
        idle(3);

        // reset in the middle of traffic
        step(1'b1, 64'h400, 1'b0, 64'h0, 1'b0, 1'b0);
        step(1'b1, 64'h408, 1'b1, 64'h500, 1'b0, 1'b1);
        idle(4);

        // mixed random traffic
        for (int i = 0; i < 60; i++) begin
            logic [63:0] ia, da;
            ia = {53'h0, 8'($urandom_range(0, 255)), 3'b000};
            da = {53'h0, 8'($urandom_range(0, 255)), 3'b000};
            if ($urandom_range(0, 7) == 0) ia = ia | 64'h1;
            if ($urandom_range(0, 7) == 0) da = da | 64'h10_0000;
            step(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), da,
                 1'($urandom_range(0, 7) == 0), 1'b0);
        end
        idle(3);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
